// File: rtl/nibble_loader.sv
// nibble_loader: serial-to-parallel front end for the 4-bit datapath stage.
// A frame is one start (with its mode bit) followed by four qualified serial
// bits. The finished word is presented on b0..b3/s under a valid/ready
// handshake.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start, mode_in  frame request and its select bit
//   sdi, sdi_valid  serial data and qualifier (sampled only in SHIFT)
//   busy            state != IDLE
//   b0..b3, s       registered parallel word and select
//   out_valid       word is complete and stable
//   out_ready       downstream accepts when out_valid & out_ready
//   frame_cnt       accepted frames, wraps modulo 2^CNT_W
//   err_start       one-cycle pulse for every start that could not be taken
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | collecting four valid serial bits
// HOLD  | word presented, waiting for out_ready
module nibble_loader #(
  parameter int LSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_in,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             busy,
  output logic             b0,
  output logic             b1,
  output logic             b2,
  output logic             b3,
  output logic             s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_start
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [3:0]         shift_q, shift_d;
  logic [3:0]         word_q, word_d;
  logic               mode_q, mode_d;
  logic               s_q, s_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               err_q, err_d;
  logic [1:0]         pos;

  // Bit slot for the current serial bit; MSB-first fills b3 down to b0.
  assign pos = (LSB_FIRST != 0) ? cnt_q : (2'd3 - cnt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      shift_q     <= 4'd0;
      word_q      <= 4'd0;
      mode_q      <= 1'b0;
      s_q         <= 1'b0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      mode_q      <= mode_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    mode_d      = mode_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_in;
          cnt_d   = 2'd0;
          shift_d = 4'd0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (start) err_d = 1'b1;
        if (sdi_valid) begin
          shift_d[pos] = sdi;
          cnt_d        = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Load straight from shift_d so the fourth bit lands this edge.
            word_d      = shift_d;
            s_d         = mode_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (start) begin
            // Back-to-back frame: skip the IDLE cycle entirely.
            mode_d  = mode_in;
            cnt_d   = 2'd0;
            shift_d = 4'd0;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign b0        = word_q[0];
  assign b1        = word_q[1];
  assign b2        = word_q[2];
  assign b3        = word_q[3];
  assign s         = s_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign err_start = err_q;

endmodule

// File: tb/tb_nibble_loader.sv
// Bench for nibble_loader. Two instances share one stimulus stream:
// u_lsb (LSB_FIRST=1, CNT_W=8) and u_msb (LSB_FIRST=0, CNT_W=2). A frame-level
// reference model (phase, queue of collected bits, accepted-frame count)
// predicts both.
module tb_nibble_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, mode_in = 1'b0, sdi = 1'b0, sdi_valid = 1'b0, out_ready = 1'b0;

  logic       l_busy, l_b0, l_b1, l_b2, l_b3, l_s, l_valid, l_err;
  logic [7:0] l_cnt;
  logic       m_busy, m_b0, m_b1, m_b2, m_b3, m_s, m_valid, m_err;
  logic [1:0] m_cnt2;

  always #5 clk = ~clk;

  nibble_loader #(.LSB_FIRST(1), .CNT_W(8)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .sdi(sdi),
    .sdi_valid(sdi_valid), .busy(l_busy), .b0(l_b0), .b1(l_b1), .b2(l_b2),
    .b3(l_b3), .s(l_s), .out_valid(l_valid), .out_ready(out_ready),
    .frame_cnt(l_cnt), .err_start(l_err)
  );

  nibble_loader #(.LSB_FIRST(0), .CNT_W(2)) u_msb (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .sdi(sdi),
    .sdi_valid(sdi_valid), .busy(m_busy), .b0(m_b0), .b1(m_b1), .b2(m_b2),
    .b3(m_b3), .s(m_s), .out_valid(m_valid), .out_ready(out_ready),
    .frame_cnt(m_cnt2), .err_start(m_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: 0 = idle, 1 = collecting, 2 = holding a finished word.
  int         ph;
  bit         bits[$];
  bit         mode_r;
  logic [3:0] w_lsb, w_msb;
  bit         s_r, err_r;
  int         acc;

  function automatic logic [3:0] pack(input bit lsb_first);
    logic [3:0] w = 4'd0;
    for (int i = 0; i < 4; i++) w[lsb_first ? i : 3 - i] = bits[i];
    return w;
  endfunction

  task automatic model_reset();
    ph = 0; bits.delete(); mode_r = 0; w_lsb = 0; w_msb = 0;
    s_r = 0; err_r = 0; acc = 0;
  endtask

  task automatic model_step();
    err_r = 0;
    if (ph == 0) begin
      if (start) begin mode_r = mode_in; bits.delete(); ph = 1; end
    end else if (ph == 1) begin
      if (start) err_r = 1;
      if (sdi_valid) begin
        bits.push_back(sdi);
        if (bits.size() == 4) begin
          w_lsb = pack(1); w_msb = pack(0); s_r = mode_r; ph = 2;
        end
      end
    end else begin
      if (out_ready) begin
        acc++;
        if (start) begin mode_r = mode_in; bits.delete(); ph = 1; end
        else ph = 0;
      end else if (start) err_r = 1;
    end
  endtask

  task automatic compare_all();
    check("lsb_busy",  l_busy,  (ph != 0));
    check("lsb_valid", l_valid, (ph == 2));
    check("lsb_word",  {l_b3, l_b2, l_b1, l_b0}, w_lsb);
    check("lsb_s",     l_s,     s_r);
    check("lsb_cnt",   l_cnt,   acc % 256);
    check("lsb_err",   l_err,   err_r);
    check("msb_busy",  m_busy,  (ph != 0));
    check("msb_valid", m_valid, (ph == 2));
    check("msb_word",  {m_b3, m_b2, m_b1, m_b0}, w_msb);
    check("msb_s",     m_s,     s_r);
    check("msb_cnt",   m_cnt2,  acc % 4);
    check("msb_err",   m_err,   err_r);
  endtask

  task automatic cyc(input logic st, input logic md, input logic d, input logic dv, input logic rdy);
    start = st; mode_in = md; sdi = d; sdi_valid = dv; out_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask

  // ser[0] is the first serial bit; bits on consecutive cycles, no accept.
  task automatic frame(input logic md, input logic [3:0] ser);
    cyc(1, md, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, ser[i], 1, 0);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // 1: LSB-first word, out_valid after the 4th bit, then accept.
    frame(1, 4'b0110);
    check("t1_word", {l_b3, l_b2, l_b1, l_b0}, 4'b0110);
    check("t1_s", l_s, 1'b1);
    check("t1_valid", l_valid, 1'b1);
    cyc(0, 0, 0, 0, 1);
    check("t1_cnt", l_cnt, 8'd1);

    // 2: gapped bits; MSB-first instance maps first bit to b3.
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, (i == 1 || i == 2), 1, 0);
      if (i < 3) begin
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t2_no_valid", m_valid, 1'b0);
        check("t2_word_held", {m_b3, m_b2, m_b1, m_b0}, 4'b0110);
      end
    end
    check("t2_word", {m_b3, m_b2, m_b1, m_b0}, 4'b0110);
    check("t2_valid", m_valid, 1'b1);
    cyc(0, 0, 0, 0, 1);

    // 3: backpressure with two start pulses.
    frame(0, 4'b1011);
    for (int i = 0; i < 10; i++) begin
      cyc((i == 3 || i == 7), 1, 1, 1, 0);
      if (i == 3 || i == 7) check("t3_err", l_err, 1'b1);
      check("t3_word", {l_b3, l_b2, l_b1, l_b0}, 4'b1011);
    end
    check("t3_cnt", l_cnt, 8'd2);
    cyc(0, 0, 0, 0, 1);

    // 4: back-to-back start during the accept; s keeps the previous value.
    frame(1, 4'b0001);
    cyc(1, 0, 0, 0, 1);
    check("t4_busy", l_busy, 1'b1);
    check("t4_valid", l_valid, 1'b0);
    check("t4_s_prev", l_s, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0);
    check("t4_s_new", l_s, 1'b0);
    cyc(0, 0, 0, 0, 1);

    // 5: 2-bit frame counter wraps: 1,2,3,0,1.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      logic [1:0] want [5];
      want = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      frame(f[0], 4'(f));
      cyc(0, 0, 0, 0, 1);
      check("t5_cnt", m_cnt2, want[f]);
    end

    // 6: reset mid-frame, then a clean frame with no stale bits.
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    do_reset();
    check("t6_busy", l_busy, 1'b0);
    check("t6_word0", {l_b3, l_b2, l_b1, l_b0}, 4'b0000);
    frame(0, 4'b1001);
    check("t6_word", {l_b3, l_b2, l_b1, l_b0}, 4'b1001);
    check("t6_s", l_s, 1'b0);
    cyc(0, 0, 0, 0, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
